// File: rtl/fir_stream_sink_if.sv
// Valid/ready result stream carrying a data beat and per-byte strobes.
// The sink modport is used by fir_stream_sink; the source modport by whoever feeds it.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/fir_stream_sink.sv
// Result sink: accepts len_i beats into a show-ahead FIFO (write-to-read one cycle), pulses done_o once drained.
// Ready is withheld outside RECV, when enable_i is low or the FIFO is full; FIR_STREAM_SINK_CHECKSUM_EN adds a running checksum.
module fir_stream_sink #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  hwpe_stream_intf_stream.sink  push_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic [31:0]           checksum_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic fifo_empty, fifo_full, push_hs, pop;
  logic unused_strb;

  // Extra MSB on each pointer tells a full FIFO from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_i.ready = (state_q == RECV) && enable_i && !fifo_full;
  assign push_hs      = push_i.valid && push_i.ready && !clear_i;
  assign pop          = rd_en_i && !fifo_empty && !clear_i;
  assign unused_strb  = ^push_i.strb;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    len_d    = len_q;
    if (clear_i) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_hs) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            count_d = '0;
            if (len_i != '0) begin
              len_d   = len_i;
              state_d = RECV;
            end else begin
              state_d = DONE;
            end
          end
        end
        RECV: begin
          if (push_hs) begin
            count_d = count_q + CNT_ONE;
            if (count_d == len_q) state_d = DRAIN;
          end
        end
        DRAIN:   if (fifo_empty) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      len_q    <= len_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_hs) mem_q[wr_ptr_q[AW-1:0]] <= push_i.data;
  end

`ifdef FIR_STREAM_SINK_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clear_i || ((state_q == IDLE) && start_i)) begin
      checksum_d = '0;
    end else if (push_hs) begin
      checksum_d = checksum_q + 32'($signed(push_i.data));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign rd_valid_o = !fifo_empty;
  assign rd_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o    = count_q;
  assign busy_o     = (state_q == RECV) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_fir_stream_sink.sv
// Bench for fir_stream_sink: queue-based reference model compared every cycle, plus directed scenarios.
module tb_fir_stream_sink;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = 16;
`ifdef FIR_STREAM_SINK_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b1, start = 1'b0;
  logic rd_en = 1'b0, valid = 1'b0;
  logic [CW-1:0] len = '0;
  logic [DW-1:0] pdata = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid, busy, done;
  logic [CW-1:0] count;
  logic [31:0] checksum;

  int total = 0, bad = 0;
  int done_cnt = 0, ready_cnt = 0;
  int pop_mode = 0;
  bit stall_en = 1'b0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] dut_pop[$];

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  assign push_if.valid = valid;
  assign push_if.data  = pdata;
  assign push_if.strb  = '1;

  fir_stream_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .start_i(start), .len_i(len), .push_i(push_if), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .count_o(count),
    .checksum_o(checksum), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 receiving, 2 draining, 3 done.
  int m_phase = 0;
  int m_cnt = 0;
  int m_len = 0;
  logic [31:0] m_sum = '0;
  logic [DW-1:0] m_q[$];
  bit m_hs = 1'b0;

  function automatic bit m_ready();
    return (m_phase == 1) && enable && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] sext(logic [DW-1:0] d);
    logic signed [DW-1:0] s;
    s = d;
    return 32'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy, was_empty, pop;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_len = 0; m_sum = '0; m_hs = 1'b0;
      m_q.delete();
    end else begin
      rdy = m_ready();
      was_empty = (m_q.size() == 0);
      pop = rd_en && !was_empty;
      m_hs = 1'b0;
      if (clear) begin
        m_phase = 0; m_cnt = 0; m_sum = '0;
        m_q.delete();
      end else begin
        m_hs = valid && rdy;
        if (pop) void'(m_q.pop_front());
        if (m_hs) m_q.push_back(pdata);
        case (m_phase)
          0: if (start) begin
               m_cnt = 0; m_sum = '0;
               if (len != 0) begin m_len = int'(len); m_phase = 1; end
               else m_phase = 3;
             end
          1: if (m_hs) begin
               m_cnt++;
               m_sum = m_sum + sext(pdata);
               if (m_cnt == m_len) m_phase = 2;
             end
          2: if (was_empty) m_phase = 3;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Beat source: holds each beat until the model reports it accepted.
  always @(posedge clk) begin
    #2;
    if (m_hs && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0 && (!stall_en || $urandom_range(9) != 0)) begin
      valid = 1'b1; pdata = src_q[0];
    end else begin
      valid = 1'b0; pdata = '0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (pop_mode == 2) rd_en = ($urandom_range(9) != 0);
  end

  always @(negedge clk) begin : compare
    logic [DW-1:0] exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : '0;
    chk("ready", push_if.ready, m_ready());
    chk("rd_valid", rd_valid, m_q.size() > 0);
    chk("rd_data", rd_data, exp_head);
    chk("count", count, CW'(m_cnt));
    chk("checksum", checksum, CK_ON ? m_sum : 32'd0);
    chk("busy", busy, (m_phase == 1) || (m_phase == 2));
    chk("done", done, m_phase == 3);
    if (done) done_cnt++;
    if (push_if.ready) ready_cnt++;
    if (rd_en && rd_valid) dut_pop.push_back(rd_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(string name, int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, done_cnt != base, 1);
  endtask

  task automatic go(int n);
    len = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base, rbase, errs;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", push_if.ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();

    // len=4, data 1,2,3,-1, always popping
    src_q = '{16'd1, 16'd2, 16'd3, 16'hFFFF};
    rd_en = 1'b1;
    repeat (2) tick();
    base = done_cnt;
    go(4);
    wait_done("len4", 50);
    chk("len4_count", count, 4);
    chk("len4_checksum", checksum, CK_ON ? 32'd5 : 32'd0);
    repeat (3) tick();
    chk("len4_done_pulses", done_cnt - base, 1);
    chk("len4_count_held", count, 4);

    // len=12 with no pops: backpressure at DEPTH
    rd_en = 1'b0;
    for (int i = 0; i < 12; i++) src_q.push_back(16'(100 + i));
    repeat (2) tick();
    base = done_cnt;
    go(12);
    repeat (20) tick();
    chk("full_count", count, 8);
    chk("full_ready", push_if.ready, 0);
    chk("full_busy", busy, 1);
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    repeat (5) tick();
    chk("full_count12", count, 12);
    chk("full_no_done", done_cnt - base, 0);
    chk("full_head", rd_data, 104);
    rd_en = 1'b1;
    wait_done("len12", 50);
    chk("len12_one_done", done_cnt - base, 1);

    // len=0: straight to DONE, ready never raised
    rbase = ready_cnt;
    len = '0;
    start = 1'b1;
    tick();
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    start = 1'b0;
    tick();
    chk("len0_done_drop", done, 0);
    repeat (3) tick();
    chk("len0_no_ready", ready_cnt - rbase, 0);

    // enable low for 5 cycles mid-transfer
    for (int i = 0; i < 10; i++) src_q.push_back(16'(20 + i));
    repeat (2) tick();
    go(10);
    repeat (3) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("en_low_count", count, 3);
      chk("en_low_ready", push_if.ready, 0);
    end
    enable = 1'b1;
    wait_done("en", 60);
    chk("en_count", count, 10);

    // clear after 3 of 10 beats
    rd_en = 1'b0;
    for (int i = 0; i < 10; i++) src_q.push_back(16'(40 + i));
    repeat (2) tick();
    base = done_cnt;
    go(10);
    repeat (3) tick();
    chk("clr_pre_count", count, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    src_q.delete();
    chk("clr_rd_valid", rd_valid, 0);
    chk("clr_count", count, 0);
    chk("clr_busy", busy, 0);
    repeat (4) tick();
    chk("clr_no_done", done_cnt - base, 0);
    src_q = '{16'd7, 16'd8, 16'd9, 16'd10};
    rd_en = 1'b1;
    repeat (2) tick();
    go(4);
    wait_done("after_clr", 50);
    chk("after_clr_count", count, 4);

    // reset mid-transfer discards contents, no done
    rd_en = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(16'(60 + i));
    repeat (2) tick();
    base = done_cnt;
    go(6);
    repeat (3) tick();
    rst_n = 1'b0;
    src_q.delete();
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_busy", busy, 0);
    tick();
    chk("arst_count", count, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("arst_no_done", done_cnt - base, 0);

    // len=512 with random valid and rd_en stalls
    dut_pop.delete();
    for (int i = 0; i < 512; i++) src_q.push_back(16'(i * 13 + 7));
    stall_en = 1'b1;
    pop_mode = 2;
    repeat (2) tick();
    go(512);
    wait_done("rand", 4000);
    pop_mode = 0;
    rd_en = 1'b0;
    stall_en = 1'b0;
    chk("rand_count", count, 512);
    chk("rand_popped", dut_pop.size(), 512);
    errs = 0;
    for (int i = 0; i < dut_pop.size(); i++)
      if (dut_pop[i] !== 16'(i * 13 + 7)) errs++;
    chk("rand_order", errs, 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_stream_sink.md
FIR_STREAM_SINK -- requirements
Module: fir_stream_sink

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the stream beat data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the internal FIFO depth in beats (power of two, >=2).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the length and beat counters.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock, rising-edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-007 The block SHALL have port enable_i, input, 1 bit: when low, the block withholds push_i.ready.
REQ-008 The block SHALL have port start_i, input, 1 bit: single-cycle start request.
REQ-009 The block SHALL have port len_i, input, CNT_WIDTH bits: number of beats to receive, sampled on an accepted start.
REQ-010 The block SHALL have port push_i, hwpe_stream_intf_stream sink modport, DATA_WIDTH bits: incoming result stream (data, valid, ready, strb).
REQ-011 The block SHALL have port rd_en_i, input, 1 bit: FIFO pop request.
REQ-012 The block SHALL have port rd_data_o, output, DATA_WIDTH bits: FIFO head data (show-ahead).
REQ-013 The block SHALL have port rd_valid_o, output, 1 bit: FIFO non-empty.
REQ-014 The block SHALL have port count_o, output, CNT_WIDTH bits: beats accepted in the current transfer.
REQ-015 The block SHALL have port checksum_o, output, 32 bits: running sum of accepted beats.
REQ-016 The block SHALL have port busy_o, output, 1 bit: high in RECV and DRAIN.
REQ-017 The block SHALL have port done_o, output, 1 bit: single-cycle end-of-transfer pulse.

Function
REQ-018 The FSM SHALL have states IDLE, RECV, DRAIN and DONE; done_o SHALL be high exactly in DONE.
REQ-019 In IDLE, start_i with len_i>0 SHALL latch len_i, zero count_o and checksum_o, and enter RECV next cycle; with len_i==0 it SHALL enter DONE directly.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 push_i.ready SHALL equal (state==RECV) & enable_i & ~fifo_full, driven from registered state only (no combinational path from push_i.valid).
REQ-022 A handshake (valid & ready) SHALL write data into the FIFO and increment count_o in the same edge; strb SHALL be ignored.
REQ-023 When the handshake makes count_o equal the latched length, the FSM SHALL enter DRAIN next cycle and ready SHALL be low from that cycle on.
REQ-024 DRAIN SHALL move to DONE in the cycle after the FIFO becomes empty; DONE SHALL return to IDLE after one cycle.
REQ-025 rd_valid_o SHALL be ~fifo_empty; rd_en_i & rd_valid_o SHALL pop the head; rd_en_i on an empty FIFO SHALL be ignored.
REQ-026 A simultaneous push and pop SHALL keep occupancy constant; a push is never accepted while full, even when a pop occurs in the same cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-028 count_o and checksum_o SHALL hold their final values in IDLE until the next accepted start or clear.
REQ-029 clear_i SHALL have priority over all other events: state to IDLE, FIFO emptied, count_o and checksum_o zeroed, done_o low.

Reset
REQ-030 On rst_ni low the block SHALL asynchronously enter IDLE, with pointers, count_o, checksum_o and the latched length all zero.
REQ-031 Under reset, push_i.ready, rd_valid_o, busy_o and done_o SHALL be 0, and rd_data_o SHALL be 0.
REQ-032 A reset mid-transfer SHALL discard all FIFO contents without generating done_o.

Configuration
REQ-033 With macro FIR_STREAM_SINK_CHECKSUM_EN defined, each handshake SHALL add the sign-extended data beat to checksum_o modulo 2^32.
REQ-034 Without FIR_STREAM_SINK_CHECKSUM_EN, no checksum register SHALL be built and checksum_o SHALL be tied to 0.

Verification
REQ-035 A bench SHALL check: start len=4 with data 1,2,3,-1, consumer always popping -> count_o=4, checksum_o=5 (macro on), single done_o pulse after the last pop.
REQ-036 A bench SHALL check: len=12, DEPTH=8, no pops -> ready drops after 8 beats; popping 4 beats accepts the remaining 4; done_o only after the FIFO is empty.
REQ-037 A bench SHALL check: start with len=0 -> done_o high the next cycle, and no ready ever asserted.
REQ-038 A bench SHALL check: enable_i low for 5 cycles mid-transfer -> ready low, count frozen, and the transfer completes correctly afterwards.
REQ-039 A bench SHALL check: clear_i after 3 of 10 beats -> IDLE next cycle, rd_valid_o=0, count_o=0, no done_o; a new start then works.
REQ-040 A bench SHALL check: random valid and rd_en stalls (probability 0.1), len=512 -> popped data equals the pushed sequence in order and count_o=512.
